// File: rtl/ifetch.sv
// ifetch: fetch / program-counter stage of the 16-bit lab CPU.
// Owns the PC, fetches one word per instruction over imem_req/imem_ack,
// presents it to the decoder for one EXEC cycle, then picks the next PC
// from the decoder's pc_sel / jump_target. Also holds the JE/JNE equality
// flag and the halt state.
// Optional: define IFETCH_STALL_EN to add a `stall` input and STALL state
// that parks the stage between instructions.
module ifetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic [15:0]     imem_data,
  input  logic            imem_ack,
  output logic [15:0]     instruction,
  output logic            inst_valid,
  input  logic [2:0]      pc_sel,
  input  logic [PC_W-1:0] jump_target,
  input  logic            cmp_write,
  input  logic            cmp_eq,
`ifdef IFETCH_STALL_EN
  input  logic            stall,
`endif
  output logic [PC_W-1:0] pc,
  output logic            eq_flag,
  output logic            halted
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3
`ifdef IFETCH_STALL_EN
    ,STALL = 3'd4
`endif
  } state_t;

  localparam logic [2:0] SEL_INC = 3'b000;
  localparam logic [2:0] SEL_JMP = 3'b001;
  localparam logic [2:0] SEL_JE  = 3'b010;
  localparam logic [2:0] SEL_JNE = 3'b011;
  localparam logic [2:0] SEL_HLT = 3'b100;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_inc, next_pc;
  logic            go_stall;

  assign pc_inc = pc + PC_W'(1);

`ifdef IFETCH_STALL_EN
  assign go_stall = stall;
`else
  assign go_stall = 1'b0;
`endif

  // Next-PC select; reserved encodings 101-111 fall through to INC.
  always_comb begin
    next_pc = pc_inc;
    case (pc_sel)
      SEL_INC: next_pc = pc_inc;
      SEL_JMP: next_pc = jump_target;
      SEL_JE:  next_pc = eq_flag ? jump_target : pc_inc;
      SEL_JNE: next_pc = eq_flag ? pc_inc : jump_target;
      SEL_HLT: next_pc = pc;
      default: next_pc = pc_inc;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next-state and control outputs, all decoded straight from the state.
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    halted     = 1'b0;
    case (state_q)
      BOOT:  state_d = go_stall ? state_t'(3'd4) : FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = EXEC;
      end
      EXEC: begin
        inst_valid = 1'b1;
        if (pc_sel == SEL_HLT) state_d = HALT;
        else if (go_stall)     state_d = state_t'(3'd4);
        else                   state_d = FETCH;
      end
      HALT: halted = 1'b1;
`ifdef IFETCH_STALL_EN
      STALL: if (!stall) state_d = FETCH;
`endif
      default: state_d = BOOT;
    endcase
  end

  // Datapath: capture the word on ack in FETCH; update PC and flag only in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instruction <= 16'h0000;
      eq_flag     <= 1'b0;
    end else begin
      if (state_q == FETCH && imem_ack) instruction <= imem_data;
      if (state_q == EXEC) begin
        pc <= next_pc;
        if (cmp_write) eq_flag <= cmp_eq;
      end
    end
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed plus randomized bench for ifetch with a
// PC/flag reference model computed from the next-PC rules.
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr, imem_data, instruction, jump_target, pc;
  logic        imem_req, imem_ack, inst_valid, cmp_write, cmp_eq, eq_flag, halted;
  logic [2:0]  pc_sel;
`ifdef IFETCH_STALL_EN
  logic        stall;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_pc;
  logic        m_eq;
  logic        m_halt;
  logic [15:0] m_inst;

  ifetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .imem_ack(imem_ack),
    .instruction(instruction), .inst_valid(inst_valid),
    .pc_sel(pc_sel), .jump_target(jump_target),
    .cmp_write(cmp_write), .cmp_eq(cmp_eq),
`ifdef IFETCH_STALL_EN
    .stall(stall),
`endif
    .pc(pc), .eq_flag(eq_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: dly wait cycles in FETCH, then ack, then EXEC.
  task automatic do_instr(input int dly, input logic [15:0] data, input logic [2:0] sel,
                          input logic [15:0] tgt, input logic cw, input logic ce);
    logic [15:0] inc;
    for (int k = 0; k < dly; k++) begin
      imem_ack = 1'b0; imem_data = 16'($urandom);
      pc_sel = 3'($urandom); jump_target = 16'($urandom);
      cmp_write = 1'($urandom); cmp_eq = 1'($urandom);
      chk("wait_req", {31'd0, imem_req}, 1);
      chk("wait_addr", {16'd0, imem_addr}, {16'd0, m_pc});
      chk("wait_valid", {31'd0, inst_valid}, 0);
      chk("wait_inst_hold", {16'd0, instruction}, {16'd0, m_inst});
      step();
    end
    chk("req", {31'd0, imem_req}, 1);
    chk("addr", {16'd0, imem_addr}, {16'd0, m_pc});
    chk("pre_ack_valid", {31'd0, inst_valid}, 0);
    imem_ack = 1'b1; imem_data = data;
    step();
    m_inst = data;
    // stray ack/data during EXEC must be ignored
    imem_ack = 1'($urandom); imem_data = 16'($urandom);
    chk("exec_valid", {31'd0, inst_valid}, 1);
    chk("exec_inst", {16'd0, instruction}, {16'd0, data});
    chk("exec_req", {31'd0, imem_req}, 0);
    pc_sel = sel; jump_target = tgt; cmp_write = cw; cmp_eq = ce;
    step();
    imem_ack = 1'b0;
    inc = m_pc + 16'd1;
    case (sel)
      3'd1:    m_pc = tgt;
      3'd2:    m_pc = m_eq ? tgt : inc;
      3'd3:    m_pc = m_eq ? inc : tgt;
      3'd4:    m_halt = 1'b1;
      default: m_pc = inc;
    endcase
    if (cw) m_eq = ce;
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("eq_flag", {31'd0, eq_flag}, {31'd0, m_eq});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("post_inst_hold", {16'd0, instruction}, {16'd0, m_inst});
    chk("post_valid", {31'd0, inst_valid}, 0);
  endtask

  task automatic reset_model();
    m_pc = 16'h0000; m_eq = 1'b0; m_halt = 1'b0; m_inst = 16'h0000;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = 16'h0; pc_sel = 3'd0;
    jump_target = 16'h0; cmp_write = 1'b0; cmp_eq = 1'b0;
`ifdef IFETCH_STALL_EN
    stall = 1'b0;
`endif
    reset_model();
    step(); step();
    chk("rst_pc", {16'd0, pc}, 0);
    chk("rst_req", {31'd0, imem_req}, 0);
    chk("rst_valid", {31'd0, inst_valid}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_eq", {31'd0, eq_flag}, 0);
    chk("rst_inst", {16'd0, instruction}, 0);
    rst = 1'b0;
    step();  // BOOT -> FETCH

    // sequential fetch, ack delayed 3 cycles at addr 2
    do_instr(0, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    do_instr(0, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    do_instr(3, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    do_instr(0, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("seq_pc4", {16'd0, pc}, 4);

    // CMP equal, then JE taken
    do_instr(0, 16'h2000, 3'd0, 16'h0, 1'b1, 1'b1);
    do_instr(0, 16'h3000, 3'd2, 16'h0020, 1'b0, 1'b0);
    chk("je_taken", {16'd0, imem_addr}, 16'h0020);

    // JMP to 7, JNE not taken, CMP unequal, JNE taken
    do_instr(1, 16'h4000, 3'd1, 16'h0007, 1'b0, 1'b0);
    do_instr(0, 16'h5000, 3'd3, 16'h0040, 1'b0, 1'b0);
    chk("jne_not_taken", {16'd0, pc}, 16'h0008);
    do_instr(0, 16'h2000, 3'd0, 16'h0, 1'b1, 1'b0);
    do_instr(2, 16'h5000, 3'd3, 16'h0030, 1'b0, 1'b0);
    chk("jne_taken", {16'd0, pc}, 16'h0030);

    // JMP to 0xFFFF then INC wraps
    do_instr(0, 16'h4000, 3'd1, 16'hFFFF, 1'b0, 1'b0);
    chk("jmp_ffff", {16'd0, pc}, 16'hFFFF);
    do_instr(0, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    chk("wrap", {16'd0, pc}, 16'h0000);

    // randomized instruction stream (no HLT)
    for (int i = 0; i < 200; i++) begin
      int s;
      s = $urandom_range(0, 6);
      if (s >= 4) s++;
      do_instr($urandom_range(0, 3), 16'($urandom), 3'(s), 16'($urandom),
               1'($urandom), 1'($urandom));
    end

    // halt at pc 5 with stray acks
    do_instr(0, 16'h4000, 3'd1, 16'h0005, 1'b0, 1'b0);
    do_instr(0, 16'hF000, 3'd4, 16'h1234, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      imem_ack = 1'($urandom); imem_data = 16'($urandom);
      pc_sel = 3'($urandom); jump_target = 16'($urandom);
      cmp_write = 1'($urandom); cmp_eq = 1'($urandom);
      step();
      chk("halt_halted", {31'd0, halted}, 1);
      chk("halt_req", {31'd0, imem_req}, 0);
      chk("halt_pc", {16'd0, pc}, 5);
      chk("halt_valid", {31'd0, inst_valid}, 0);
    end
    imem_ack = 1'b0;

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("arst_halted", {31'd0, halted}, 0);
    chk("arst_pc", {16'd0, pc}, 0);
    chk("arst_req", {31'd0, imem_req}, 0);
    chk("arst_eq", {31'd0, eq_flag}, 0);
    reset_model();
    step();
    rst = 1'b0;
    step();  // BOOT -> FETCH
    do_instr(0, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    do_instr(1, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);
    do_instr(0, 16'h1001, 3'd0, 16'h0, 1'b0, 1'b0);

`ifdef IFETCH_STALL_EN
    // stall during EXEC of INC at pc 3
    chk("stall_addr3", {16'd0, imem_addr}, 3);
    imem_ack = 1'b1; imem_data = 16'h1001;
    step();
    imem_ack = 1'b0;
    chk("stall_exec_valid", {31'd0, inst_valid}, 1);
    pc_sel = 3'd0; cmp_write = 1'b0; stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_req", {31'd0, imem_req}, 0);
      chk("stall_pc", {16'd0, pc}, 4);
      chk("stall_valid", {31'd0, inst_valid}, 0);
      imem_ack = 1'($urandom);
    end
    imem_ack = 1'b0;
    stall = 1'b0;
    step();
    chk("unstall_req", {31'd0, imem_req}, 1);
    chk("unstall_addr", {16'd0, imem_addr}, 4);
`else
    chk("seq_after_rst", {16'd0, pc}, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
